// File: rtl/mips_alu_pkg.sv
// Shared types and constants for the MIPS execute-stage ALU.
package mips_alu_pkg;

    // Operation class from the main control unit
    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_RTYPE = 3'b010,
        OP_AND   = 3'b011,
        OP_OR    = 3'b100,
        OP_SLT   = 3'b101,
        OP_LUI   = 3'b110,
        OP_RSVD  = 3'b111
    } alu_op_t;

    // Decoded ALU control code
    typedef enum logic [3:0] {
        CTL_AND     = 4'b0000,
        CTL_OR      = 4'b0001,
        CTL_ADD     = 4'b0010,
        CTL_XOR     = 4'b0011,
        CTL_SLTU    = 4'b0100,
        CTL_SUB     = 4'b0110,
        CTL_SLT     = 4'b0111,
        CTL_SLL     = 4'b1000,
        CTL_SRL     = 4'b1001,
        CTL_SRA     = 4'b1010,
        CTL_NOR     = 4'b1100,
        CTL_LUI     = 4'b1101,
        CTL_INVALID = 4'b1111
    } alu_ctl_t;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

endpackage

// File: rtl/alu_adder32.sv
// Plain wrapping adder used for the PC increment and branch target.
module alu_adder32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Sum modulo 2^WIDTH; carry-out is intentionally dropped
    always_comb begin
        y = a + b;
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU-control decode, 32-bit ALU, PC+4 and branch target, all registered.
module alu_exec_unit
    import mips_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         alu_op,
    input  logic [5:0]         funct,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   pc,
    input  logic [WIDTH-1:0]   branch_offset,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               jr,
    output logic [3:0]         alu_ctl,
    output logic [WIDTH-1:0]   pc_plus_4,
    output logic [WIDTH-1:0]   branch_target
);

    alu_ctl_t          ctl_d;
    logic              jr_d;
    logic [WIDTH-1:0]  res_d;
    logic [WIDTH-1:0]  pc4_d;
    logic [WIDTH-1:0]  tgt_d;

    // Map the operation class (and funct for R-type) to an ALU control code
    always_comb begin
        ctl_d = CTL_INVALID;
        case (alu_op_t'(alu_op))
            OP_ADD:   ctl_d = CTL_ADD;
            OP_SUB:   ctl_d = CTL_SUB;
            OP_AND:   ctl_d = CTL_AND;
            OP_OR:    ctl_d = CTL_OR;
            OP_SLT:   ctl_d = CTL_SLT;
            OP_LUI:   ctl_d = CTL_LUI;
            OP_RTYPE: begin
                case (funct)
                    FUNCT_ADD, FUNCT_ADDU: ctl_d = CTL_ADD;
                    FUNCT_SUB, FUNCT_SUBU: ctl_d = CTL_SUB;
                    FUNCT_AND:             ctl_d = CTL_AND;
                    FUNCT_OR:              ctl_d = CTL_OR;
                    FUNCT_XOR:             ctl_d = CTL_XOR;
                    FUNCT_NOR:             ctl_d = CTL_NOR;
                    FUNCT_SLT:             ctl_d = CTL_SLT;
                    FUNCT_SLTU:            ctl_d = CTL_SLTU;
                    FUNCT_SLL:             ctl_d = CTL_SLL;
                    FUNCT_SRL:             ctl_d = CTL_SRL;
                    FUNCT_SRA:             ctl_d = CTL_SRA;
                    // jr still computes a+b; the core masks the write-back
                    FUNCT_JR:              ctl_d = CTL_ADD;
                    default:               ctl_d = CTL_INVALID;
                endcase
            end
            default:  ctl_d = CTL_INVALID;
        endcase
    end

    // jr depends only on the decode fields, never on operands
    always_comb begin
        jr_d = (alu_op == OP_RTYPE) && (funct == FUNCT_JR);
    end

    // ALU result mux; invalid codes produce 0 so zero reads 1
    always_comb begin
        res_d = '0;
        case (ctl_d)
            CTL_AND:  res_d = a & b;
            CTL_OR:   res_d = a | b;
            CTL_ADD:  res_d = a + b;
            CTL_XOR:  res_d = a ^ b;
            CTL_SUB:  res_d = a - b;
            CTL_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            CTL_SLTU: res_d = {{(WIDTH-1){1'b0}}, (a < b)};
            CTL_SLL:  res_d = b << shamt;
            CTL_SRL:  res_d = b >> shamt;
            CTL_SRA:  res_d = $signed(b) >>> shamt;
            CTL_NOR:  res_d = ~(a | b);
            CTL_LUI:  res_d = {b[15:0], 16'h0000};
            default:  res_d = '0;
        endcase
    end

    alu_adder32 #(.WIDTH(WIDTH)) u_pc4 (
        .a (pc),
        .b (WIDTH'(4)),
        .y (pc4_d)
    );

    alu_adder32 #(.WIDTH(WIDTH)) u_tgt (
        .a (pc4_d),
        .b (branch_offset),
        .y (tgt_d)
    );

    // Output registers: clear on reset, otherwise capture this cycle's results
    always_ff @(posedge clk) begin
        if (rst) begin
            result        <= '0;
            zero          <= 1'b0;
            jr            <= 1'b0;
            alu_ctl       <= 4'b0000;
            pc_plus_4     <= '0;
            branch_target <= '0;
        end else begin
            result        <= res_d;
            zero          <= (res_d == '0);
            jr            <= jr_d;
            alu_ctl       <= ctl_d;
            pc_plus_4     <= pc4_d;
            branch_target <= tgt_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized + directed bench for alu_exec_unit against an instruction-level reference model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] a, b, pc, branch_offset;
    logic [4:0]  shamt;
    logic [31:0] result, pc_plus_4, branch_target;
    logic        zero, jr;
    logic [3:0]  alu_ctl;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_op        (alu_op),
        .funct         (funct),
        .a             (a),
        .b             (b),
        .shamt         (shamt),
        .pc            (pc),
        .branch_offset (branch_offset),
        .result        (result),
        .zero          (zero),
        .jr            (jr),
        .alu_ctl       (alu_ctl),
        .pc_plus_4     (pc_plus_4),
        .branch_target (branch_target)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Per-instruction semantics: each row gives the control code and the value directly
    function automatic void model(
        input  logic [2:0]  op,  input logic [5:0] fn,
        input  logic [31:0] av,  input logic [31:0] bv, input logic [4:0] sh,
        input  logic [31:0] pcv, input logic [31:0] off,
        output logic [31:0] r,   output logic z, output logic j, output logic [3:0] c,
        output logic [31:0] p4,  output logic [31:0] bt);
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        r = 0; c = 4'hF; j = 0;
        case (op)
            3'd0: begin c = 4'h2; r = av + bv; end
            3'd1: begin c = 4'h6; r = av - bv; end
            3'd3: begin c = 4'h0; r = av & bv; end
            3'd4: begin c = 4'h1; r = av | bv; end
            3'd5: begin c = 4'h7; r = (int'(av) < int'(bv)) ? 1 : 0; end
            3'd6: begin c = 4'hD; r = bv * 32'h10000; end
            3'd2: begin
                if (fn == 6'h20 || fn == 6'h21)      begin c = 4'h2; r = av + bv; end
                else if (fn == 6'h22 || fn == 6'h23) begin c = 4'h6; r = av - bv; end
                else if (fn == 6'h24) begin c = 4'h0; r = av & bv; end
                else if (fn == 6'h25) begin c = 4'h1; r = av | bv; end
                else if (fn == 6'h26) begin c = 4'h3; r = av ^ bv; end
                else if (fn == 6'h27) begin c = 4'hC; r = ~(av | bv); end
                else if (fn == 6'h2A) begin c = 4'h7; r = (int'(av) < int'(bv)) ? 1 : 0; end
                else if (fn == 6'h2B) begin c = 4'h4; r = (longint'(av) < longint'(bv)) ? 1 : 0; end
                else if (fn == 6'h00) begin c = 4'h8; r = bv * (32'd1 << sh); end
                else if (fn == 6'h02) begin c = 4'h9; r = bv / (32'd1 << sh); end
                else if (fn == 6'h03) begin
                    c = 4'hA;
                    r = (bv >> sh) | (bv[31] ? ~(ones >> sh) : 32'd0);
                end
                else if (fn == 6'h08) begin c = 4'h2; r = av + bv; j = 1; end
            end
            default: begin c = 4'hF; r = 0; end
        endcase
        z  = (r == 0);
        p4 = pcv + 32'd4;
        bt = pcv + 32'd4 + off;
    endfunction

    // Drive one set of inputs, clock it in, and check all outputs
    task automatic step(input logic r, input logic [2:0] op, input logic [5:0] fn,
                        input logic [31:0] av, input logic [31:0] bv, input logic [4:0] sh,
                        input logic [31:0] pcv, input logic [31:0] off);
        logic [31:0] er, ep4, ebt;
        logic        ez, ej;
        logic [3:0]  ec;
        rst = r; alu_op = op; funct = fn; a = av; b = bv; shamt = sh;
        pc = pcv; branch_offset = off;
        @(posedge clk);
        #1;
        if (r) begin
            er = 0; ez = 0; ej = 0; ec = 0; ep4 = 0; ebt = 0;
        end else begin
            model(op, fn, av, bv, sh, pcv, off, er, ez, ej, ec, ep4, ebt);
        end
        chk("result", result, er);
        chk("zero", 32'(zero), 32'(ez));
        chk("jr", 32'(jr), 32'(ej));
        chk("alu_ctl", 32'(alu_ctl), 32'(ec));
        chk("pc_plus_4", pc_plus_4, ep4);
        chk("branch_target", branch_target, ebt);
    endtask

    function automatic logic [5:0] pick_funct();
        logic [5:0] tbl [0:15];
        tbl = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23,
                6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F, 6'h01};
        if ($urandom_range(0, 7) == 0) return 6'($urandom);
        return tbl[$urandom_range(0, 15)];
    endfunction

    initial begin
        logic [31:0] r1, r2;
        rst = 1'b1; alu_op = 0; funct = 0; a = 0; b = 0; shamt = 0; pc = 0; branch_offset = 0;

        // reset with random inputs, then release
        step(1, 3'($urandom), 6'($urandom), $urandom, $urandom, 5'($urandom), $urandom, $urandom);
        step(1, 3'($urandom), 6'($urandom), $urandom, $urandom, 5'($urandom), $urandom, $urandom);
        step(0, 3'd2, 6'h20, 32'd3, 32'd4, 5'd0, 32'h100, 32'd8);
        chk("release_result", result, 32'd7);

        // R-type add/sub
        step(0, 3'd2, 6'h20, 32'd7, 32'd5, 5'($urandom), $urandom, $urandom);
        chk("add_res", result, 32'd12); chk("add_zero", 32'(zero), 0); chk("add_ctl", 32'(alu_ctl), 32'h2);
        step(0, 3'd2, 6'h22, 32'd5, 32'd5, 5'($urandom), $urandom, $urandom);
        chk("sub_res", result, 0); chk("sub_zero", 32'(zero), 1); chk("sub_ctl", 32'(alu_ctl), 32'h6);
        step(0, 3'd2, 6'h20, 32'hFFFF_FFFF, 32'd1, 5'd0, $urandom, $urandom);
        chk("add_wrap", result, 0); chk("add_wrap_zero", 32'(zero), 1);

        // compare and shift
        step(0, 3'd2, 6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd0, 0, 0);
        chk("slt", result, 32'd1);
        step(0, 3'd2, 6'h2B, 32'hFFFF_FFFF, 32'd1, 5'd0, 0, 0);
        chk("sltu", result, 32'd0);
        step(0, 3'd2, 6'h03, $urandom, 32'h8000_0000, 5'd4, 0, 0);
        chk("sra", result, 32'hF800_0000);
        step(0, 3'd2, 6'h02, $urandom, 32'h8000_0000, 5'd4, 0, 0);
        chk("srl", result, 32'h0800_0000);
        step(0, 3'd2, 6'h00, $urandom, 32'd1, 5'd31, 0, 0);
        chk("sll", result, 32'h8000_0000);
        step(0, 3'd2, 6'h00, $urandom, 32'hDEAD_BEEF, 5'd0, 0, 0);
        chk("sll_sh0", result, 32'hDEAD_BEEF);

        // class decodes
        step(0, 3'd3, 6'($urandom), 32'hF0F0, 32'hFF00, 5'd0, 0, 0);
        chk("and", result, 32'hF000);
        step(0, 3'd4, 6'($urandom), 32'hF0F0, 32'hFF00, 5'd0, 0, 0);
        chk("or", result, 32'hFFF0);
        step(0, 3'd6, 6'($urandom), $urandom, 32'h1234, 5'd0, 0, 0);
        chk("lui", result, 32'h1234_0000);
        step(0, 3'd1, 6'($urandom), 32'd9, 32'd9, 5'd0, 0, 0);
        chk("beq_zero", 32'(zero), 1);
        step(0, 3'd2, 6'h08, $urandom, $urandom, 5'd0, 0, 0);
        chk("jr", 32'(jr), 1);
        step(0, 3'd2, 6'h3F, $urandom | 1, $urandom, 5'd0, 0, 0);
        chk("bad_ctl", 32'(alu_ctl), 32'hF); chk("bad_res", result, 0);
        step(0, 3'd7, 6'h20, 32'd1, 32'd1, 5'd0, 0, 0);
        chk("rsvd_ctl", 32'(alu_ctl), 32'hF);

        // adders
        step(0, 3'd0, 0, 0, 0, 0, 32'h0040_0000, 32'h0000_0010);
        chk("pc4", pc_plus_4, 32'h0040_0004); chk("tgt", branch_target, 32'h0040_0014);
        step(0, 3'd0, 0, 0, 0, 0, 32'h0040_0000, 32'hFFFF_FFF8);
        chk("tgt_neg", branch_target, 32'h003F_FFFC);
        step(0, 3'd0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'd0);
        chk("pc4_wrap", pc_plus_4, 32'd0);

        // random traffic with occasional mid-stream reset
        for (int i = 0; i < 400; i++) begin
            r1 = $urandom; r2 = $urandom;
            if ($urandom_range(0, 3) == 0) r2 = r1;
            step(($urandom_range(0, 15) == 0), 3'($urandom), pick_funct(), r1, r2,
                 5'($urandom), $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
